// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and encodings for the ALU command sequencer: FSM states, ALU
// mode/select codes, the latched command record and the high-half select map.
package alu_op_sequencer_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic MODE_ARITH = 1'b0;
    localparam logic MODE_LOGIC = 1'b1;

    localparam logic [3:0] SEL_ADC  = 4'd0;
    localparam logic [3:0] SEL_SBB  = 4'd1;
    localparam logic [3:0] SEL_ADD  = 4'd2;
    localparam logic [3:0] SEL_SUB  = 4'd3;
    localparam logic [3:0] SEL_AND  = 4'd0;
    localparam logic [3:0] SEL_OR   = 4'd1;
    localparam logic [3:0] SEL_XOR  = 4'd2;
    localparam logic [3:0] SEL_NAND = 4'd3;
    localparam logic [3:0] SEL_NOR  = 4'd4;
    localparam logic [3:0] SEL_XNOR = 4'd5;
    localparam logic [3:0] SEL_NOT  = 4'd6;
    localparam logic [3:0] SEL_SHL  = 4'd7;
    localparam logic [3:0] SEL_SHR  = 4'd8;

    typedef struct packed {
        logic                  mode;
        logic [3:0]            select;
        logic                  wide;
        logic                  carry_in;
        logic [2*WORD_W-1:0]   a;
        logic [2*WORD_W-1:0]   b;
    } cmd_t;

    // The upper half of a wide add/sub must consume the low-half carry/borrow.
    function automatic logic [3:0] hi_select(input logic mode, input logic [3:0] sel);
        logic [3:0] hs;
        hs = sel;
        if (mode == MODE_ARITH) begin
            if (sel == SEL_ADD) hs = SEL_ADC;
            if (sel == SEL_SUB) hs = SEL_SBB;
        end
        return hs;
    endfunction

    function automatic logic cmd_illegal(input logic mode, input logic [3:0] sel,
                                         input logic wide, input logic allow_wide);
        logic bad;
        bad = 1'b0;
        if (mode == MODE_ARITH && sel > SEL_SUB) bad = 1'b1;
        if (mode == MODE_LOGIC && sel > SEL_SHR) bad = 1'b1;
        if (wide && mode == MODE_LOGIC && (sel == SEL_SHL || sel == SEL_SHR)) bad = 1'b1;
        if (wide && !allow_wide) bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Command-level controller for a 16-bit ALU: single-pass narrow ops, two-pass
// wide ops with carry chaining, and a registered response channel.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int DATA_W     = WORD_W,
    parameter bit ALLOW_WIDE = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_mode,
    input  logic [3:0]          cmd_select,
    input  logic                cmd_wide,
    input  logic                cmd_carry_in,
    input  logic [2*DATA_W-1:0] cmd_a,
    input  logic [2*DATA_W-1:0] cmd_b,
    output logic                alu_mode,
    output logic [3:0]          alu_select,
    output logic                alu_carry_in,
    output logic [DATA_W-1:0]   alu_in_a,
    output logic [DATA_W-1:0]   alu_in_b,
    input  logic [DATA_W-1:0]   alu_out,
    input  logic                alu_carry_out,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [2*DATA_W-1:0] rsp_result,
    output logic                rsp_carry,
    output logic                rsp_zero,
    output logic                rsp_error
);

    state_t                state_q, state_d;
    cmd_t                  cmd_q, cmd_d;
    logic [DATA_W-1:0]     lo_q, lo_d;
    logic                  carry_q, carry_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [2*DATA_W-1:0]   rsp_result_q, rsp_result_d;
    logic                  rsp_carry_q, rsp_carry_d;
    logic                  rsp_zero_q, rsp_zero_d;
    logic                  rsp_error_q, rsp_error_d;

    assign cmd_ready  = (state_q == ST_IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_error  = rsp_error_q;

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        lo_d         = lo_q;
        carry_d      = carry_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_error_d  = rsp_error_q;
        alu_mode     = 1'b0;
        alu_select   = 4'd0;
        alu_carry_in = 1'b0;
        alu_in_a     = '0;
        alu_in_b     = '0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_d = '{mode: cmd_mode, select: cmd_select, wide: cmd_wide,
                              carry_in: cmd_carry_in, a: cmd_a, b: cmd_b};
                    if (cmd_illegal(cmd_mode, cmd_select, cmd_wide, ALLOW_WIDE)) begin
                        state_d      = ST_RESP;
                        rsp_valid_d  = 1'b1;
                        rsp_error_d  = 1'b1;
                        rsp_result_d = '0;
                        rsp_carry_d  = 1'b0;
                        rsp_zero_d   = 1'b0;
                    end else begin
                        state_d = ST_LO;
                    end
                end
            end
            ST_LO: begin
                alu_mode     = cmd_q.mode;
                alu_select   = cmd_q.select;
                alu_carry_in = cmd_q.carry_in;
                alu_in_a     = cmd_q.a[DATA_W-1:0];
                alu_in_b     = cmd_q.b[DATA_W-1:0];
                if (cmd_q.wide) begin
                    lo_d    = alu_out;
                    carry_d = alu_carry_out;
                    state_d = ST_HI;
                end else begin
                    state_d      = ST_RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_error_d  = 1'b0;
                    rsp_result_d = {{DATA_W{1'b0}}, alu_out};
                    rsp_carry_d  = (cmd_q.mode == MODE_ARITH) && alu_carry_out;
                    rsp_zero_d   = (alu_out == '0);
                end
            end
            ST_HI: begin
                alu_mode     = cmd_q.mode;
                alu_select   = hi_select(cmd_q.mode, cmd_q.select);
                alu_carry_in = carry_q;
                alu_in_a     = cmd_q.a[2*DATA_W-1:DATA_W];
                alu_in_b     = cmd_q.b[2*DATA_W-1:DATA_W];
                state_d      = ST_RESP;
                rsp_valid_d  = 1'b1;
                rsp_error_d  = 1'b0;
                rsp_result_d = {alu_out, lo_q};
                rsp_carry_d  = (cmd_q.mode == MODE_ARITH) && alu_carry_out;
                rsp_zero_d   = (alu_out == '0) && (lo_q == '0);
            end
            ST_RESP: begin
                // Response fields stay put after the handshake; only valid drops.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            lo_q         <= '0;
            carry_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
            rsp_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            lo_q         <= lo_d;
            carry_q      <= carry_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_error_q  <= rsp_error_d;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 16-bit ALU attached.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_mode = 1'b0;
    logic [3:0]  cmd_select = 4'd0;
    logic        cmd_wide = 1'b0;
    logic        cmd_carry_in = 1'b0;
    logic [31:0] cmd_a = 32'd0;
    logic [31:0] cmd_b = 32'd0;
    logic        alu_mode;
    logic [3:0]  alu_select;
    logic        alu_carry_in;
    logic [15:0] alu_in_a;
    logic [15:0] alu_in_b;
    logic [15:0] alu_out;
    logic        alu_carry_out;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_carry;
    logic        rsp_zero;
    logic        rsp_error;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.DATA_W(16), .ALLOW_WIDE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_select(cmd_select), .cmd_wide(cmd_wide), .cmd_carry_in(cmd_carry_in),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_mode(alu_mode), .alu_select(alu_select), .alu_carry_in(alu_carry_in),
        .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_out(alu_out),
        .alu_carry_out(alu_carry_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_error(rsp_error)
    );

    // Behavioural ALU: arith ADC/SBB/ADD/SUB with carry/borrow on bit 16.
    logic [16:0] alu_t;
    always_comb begin
        alu_t = 17'd0;
        if (alu_mode == 1'b0) begin
            case (alu_select)
                4'd0: alu_t = {1'b0, alu_in_a} + {1'b0, alu_in_b} + {16'd0, alu_carry_in};
                4'd1: alu_t = {1'b0, alu_in_a} - {1'b0, alu_in_b} - {16'd0, alu_carry_in};
                4'd2: alu_t = {1'b0, alu_in_a} + {1'b0, alu_in_b};
                4'd3: alu_t = {1'b0, alu_in_a} - {1'b0, alu_in_b};
                default: alu_t = 17'd0;
            endcase
        end else begin
            case (alu_select)
                4'd0: alu_t = {1'b0, alu_in_a & alu_in_b};
                4'd1: alu_t = {1'b0, alu_in_a | alu_in_b};
                4'd2: alu_t = {1'b0, alu_in_a ^ alu_in_b};
                default: alu_t = {1'b0, ~alu_in_a};
            endcase
        end
    end
    assign alu_out       = alu_t[15:0];
    assign alu_carry_out = alu_t[16];

    typedef struct {
        logic        mode;
        logic [3:0]  sel;
        logic        wide;
        logic        cin;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        carry;
        logic        zero;
        logic        err;
        int          lat;
        logic [3:0]  hi_sel;
        logic        hi_cin;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer one command and follow it to rsp_valid; samples taken 1 ns after each edge.
    task automatic issue(input vec_t v, output int lat, output logic [3:0] hsel,
                         output logic hcin, output logic [15:0] lo_a, output logic alu_idle);
        int w;
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        cmd_valid = 1'b1; cmd_mode = v.mode; cmd_select = v.sel; cmd_wide = v.wide;
        cmd_carry_in = v.cin; cmd_a = v.a; cmd_b = v.b;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 1; hsel = 4'hF; hcin = 1'bx; lo_a = 16'hxxxx; alu_idle = 1'b1;
        while (!rsp_valid && lat < 8) begin
            if (lat == 1) lo_a = alu_in_a;
            if (lat == 2) begin hsel = alu_select; hcin = alu_carry_in; end
            @(posedge clk); #1; lat++;
        end
        alu_idle = (alu_in_a == 16'd0) && (alu_in_b == 16'd0) && (alu_select == 4'd0);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("post_hs_ready_valid", {34'd0, cmd_ready, rsp_valid}, {34'd0, 1'b1, 1'b0});
    endtask

    initial begin
        int          lat;
        logic [3:0]  hsel;
        logic        hcin;
        logic [15:0] lo_a;
        logic        idle;

        vecs[0]  = '{1'b0, 4'd2, 1'b0, 1'b0, 32'h00000003, 32'h00000004, 32'h00000007, 1'b0, 1'b0, 1'b0, 2, 4'd0, 1'b0};
        vecs[1]  = '{1'b0, 4'd2, 1'b1, 1'b0, 32'h0001FFFF, 32'h00000001, 32'h00020000, 1'b0, 1'b0, 1'b0, 3, 4'd0, 1'b1};
        vecs[2]  = '{1'b0, 4'd3, 1'b1, 1'b0, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 3, 4'd1, 1'b1};
        vecs[3]  = '{1'b1, 4'd2, 1'b1, 1'b0, 32'h1234ABCD, 32'h1234ABCD, 32'h00000000, 1'b0, 1'b1, 1'b0, 3, 4'd2, 1'b0};
        vecs[4]  = '{1'b1, 4'd7, 1'b1, 1'b0, 32'h00001111, 32'h00002222, 32'h00000000, 1'b0, 1'b0, 1'b1, 1, 4'd0, 1'b0};
        vecs[5]  = '{1'b0, 4'd5, 1'b0, 1'b0, 32'h00000001, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b1, 1, 4'd0, 1'b0};
        vecs[6]  = '{1'b0, 4'd3, 1'b0, 1'b0, 32'hABCD0005, 32'h12340005, 32'h00000000, 1'b0, 1'b1, 1'b0, 2, 4'd0, 1'b0};
        vecs[7]  = '{1'b0, 4'd0, 1'b0, 1'b1, 32'h0000FFFF, 32'h00000000, 32'h00000000, 1'b1, 1'b1, 1'b0, 2, 4'd0, 1'b0};
        vecs[8]  = '{1'b1, 4'd0, 1'b0, 1'b0, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 1'b0, 1'b0, 1'b0, 2, 4'd0, 1'b0};
        vecs[9]  = '{1'b1, 4'd9, 1'b0, 1'b0, 32'h00000005, 32'h00000003, 32'h00000000, 1'b0, 1'b0, 1'b1, 1, 4'd0, 1'b0};
        vecs[10] = '{1'b1, 4'd1, 1'b1, 1'b0, 32'h12340000, 32'h0000ABCD, 32'h1234ABCD, 1'b0, 1'b0, 1'b0, 3, 4'd1, 1'b0};
        vecs[11] = '{1'b0, 4'd1, 1'b1, 1'b1, 32'h00010000, 32'h00000000, 32'h0000FFFF, 1'b0, 1'b0, 1'b0, 3, 4'd1, 1'b1};
        vecs[12] = '{1'b1, 4'd8, 1'b1, 1'b0, 32'h00008000, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b1, 1, 4'd0, 1'b0};
        vecs[13] = '{1'b0, 4'd3, 1'b0, 1'b0, 32'h00000001, 32'h00000002, 32'h0000FFFF, 1'b1, 1'b0, 1'b0, 2, 4'd0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {30'd0, cmd_ready, rsp_valid, rsp_carry, rsp_zero, rsp_error, |rsp_result},
              {30'd0, 1'b1, 5'b00000});
        check("reset_alu", {3'd0, alu_mode, alu_select, alu_carry_in, alu_in_a, alu_in_b[14:0]}, 36'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            issue(vecs[i], lat, hsel, hcin, lo_a, idle);
            check($sformatf("v%0d_latency", i), 36'(lat), 36'(vecs[i].lat));
            check($sformatf("v%0d_result", i), {4'd0, rsp_result}, {4'd0, vecs[i].res});
            check($sformatf("v%0d_flags", i), {33'd0, rsp_carry, rsp_zero, rsp_error},
                  {33'd0, vecs[i].carry, vecs[i].zero, vecs[i].err});
            check($sformatf("v%0d_cmd_ready_in_resp", i), {35'd0, cmd_ready}, 36'd0);
            if (vecs[i].err)
                check($sformatf("v%0d_alu_idle", i), {35'd0, idle}, 36'd1);
            else
                check($sformatf("v%0d_lo_operand", i), {20'd0, lo_a}, {20'd0, vecs[i].a[15:0]});
            if (vecs[i].wide && !vecs[i].err)
                check($sformatf("v%0d_hi_sel_cin", i), {31'd0, hsel, hcin},
                      {31'd0, vecs[i].hi_sel, vecs[i].hi_cin});
            $display("[TB] vec %0d mode=%0d sel=%0d wide=%0d a=%h b=%h -> result=%h c=%0d z=%0d e=%0d lat=%0d",
                     i, vecs[i].mode, vecs[i].sel, vecs[i].wide, vecs[i].a, vecs[i].b,
                     rsp_result, rsp_carry, rsp_zero, rsp_error, lat);
            handshake();
        end

        // Backpressure: response must hold while a competing command is offered.
        issue(vecs[0], lat, hsel, hcin, lo_a, idle);
        cmd_valid = 1'b1; cmd_mode = 1'b0; cmd_select = 4'd2; cmd_wide = 1'b0;
        cmd_a = 32'd100; cmd_b = 32'd200;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold_%0d", k), {1'b0, rsp_valid, cmd_ready, rsp_carry, rsp_result},
                  {1'b0, 1'b1, 1'b0, 1'b0, 32'h00000007});
        end
        cmd_valid = 1'b0;
        $display("[TB] backpressure held 5 cycles result=%h", rsp_result);
        handshake();

        // Reset while the high half of a wide op is on the ALU.
        issue_partial();
        check("rst_abort_state", {33'd0, rsp_valid, cmd_ready, |alu_in_a}, {33'd0, 1'b0, 1'b1, 1'b0});
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("rst_no_rsp_%0d", k), {35'd0, rsp_valid}, 36'd0);
        end
        $display("[TB] reset in HI aborted command, rsp_valid=%0d cmd_ready=%0d", rsp_valid, cmd_ready);

        issue(vecs[1], lat, hsel, hcin, lo_a, idle);
        check("recover_result", {4'd0, rsp_result}, {4'd0, 32'h00020000});
        check("recover_latency", 36'(lat), 36'd3);
        $display("[TB] recovery wide add result=%h lat=%0d", rsp_result, lat);
        handshake();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    task automatic issue_partial();
        cmd_valid = 1'b1; cmd_mode = 1'b0; cmd_select = 4'd2; cmd_wide = 1'b1;
        cmd_carry_in = 1'b0; cmd_a = 32'h0001FFFF; cmd_b = 32'h00000001;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_pre_hi", {15'd0, alu_select, alu_carry_in, alu_in_a},
              {15'd0, 4'd0, 1'b1, 16'h0001});
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "timeout");
    end

endmodule
